// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the processor controller and the stage sequencer.
// The controller side drives run/step/decoder/memory status; the sequencer drives stage and debug state.
interface stage_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Run;
  logic             Step_Mode;
  logic             Step_Pulse;
  logic             HALT_FLAG;
  logic             NOP_FLAG;
  logic             MEM_Access;
  logic             MEM_Ready;
  logic [2:0]       Stage;
  logic             Stall;
  logic             Halted;
  logic             Fault;
  logic [CNT_W-1:0] Instr_Count;
  logic [CNT_W-1:0] Cycle_Count;

  modport master (
    output Run, Step_Mode, Step_Pulse, HALT_FLAG, NOP_FLAG, MEM_Access, MEM_Ready,
    input  Stage, Stall, Halted, Fault, Instr_Count, Cycle_Count
  );

  modport slave (
    input  Run, Step_Mode, Step_Pulse, HALT_FLAG, NOP_FLAG, MEM_Access, MEM_Ready,
    output Stage, Stall, Halted, Fault, Instr_Count, Cycle_Count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: produces the 1..5 stage code, stretches Fetch/Memory
// on memory wait, retires instructions, and keeps instruction/cycle debug counters.
module stage_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned SKIP_NOP = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  stage_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  state_t           boundary;
  logic [2:0]       stage_q;
  logic [2:0]       stage_d;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [7:0]       wait_cnt;
  logic             stall;
  logic             start;
  logic             timeout;
  logic             retire;

  // Stall is driven from the registered stage so it is valid early in the cycle.
  always_comb begin
    stall = (MEM_WAIT != 0) && !bus.MEM_Ready &&
            ((stage_q == 3'd1) || ((stage_q == 3'd4) && bus.MEM_Access));
  end

  always_comb begin
    start    = bus.Step_Mode ? bus.Step_Pulse : bus.Run;
    boundary = (!bus.Step_Mode && bus.Run) ? ST_S1 : ST_IDLE;
    timeout  = stall && (wait_cnt == TIMEOUT_M1);
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_S1;
      end
      ST_S1: begin
        if (timeout)     state_d = ST_FAULT;
        else if (!stall) state_d = ST_S2;
      end
      ST_S2: begin
        if (bus.HALT_FLAG) begin
          state_d = ST_HALT;
          retire  = 1'b1;
        end else if (bus.NOP_FLAG && (SKIP_NOP != 0)) begin
          state_d = boundary;
          retire  = 1'b1;
        end else begin
          state_d = ST_S3;
        end
      end
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        if (timeout)     state_d = ST_FAULT;
        else if (!stall) state_d = ST_S5;
      end
      ST_S5: begin
        state_d = boundary;
        retire  = 1'b1;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stage_d = '0;
    case (state_d)
      ST_S1:   stage_d = 3'd1;
      ST_S2:   stage_d = 3'd2;
      ST_S3:   stage_d = 3'd3;
      ST_S4:   stage_d = 3'd4;
      ST_S5:   stage_d = 3'd5;
      default: stage_d = 3'd0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      instr_cnt <= '0;
      cycle_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      halted_q <= (state_d == ST_HALT);
      fault_q  <= (state_d == ST_FAULT);
      wait_cnt <= stall ? (wait_cnt + 8'd1) : '0;
      if (stage_q != 3'd0) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)          instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign bus.Stage       = stage_q;
  assign bus.Stall       = stall;
  assign bus.Halted      = halted_q;
  assign bus.Fault       = fault_q;
  assign bus.Instr_Count = instr_cnt;
  assign bus.Cycle_Count = cycle_cnt;

endmodule
